// File: rtl/axi4_stream_tpg_pkg.sv
// Shared types and width helpers for the AXI4-Stream test pattern generator.
package axi4_stream_tpg_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      HRAMP = 2'd0,
      VRAMP = 2'd1,
      BARS  = 2'd2,
      FLAT  = 2'd3
   } pattern_t;

   function automatic int axis_bytes(input int ncomp, input int dw);
      return (ncomp * dw + 7) / 8;
   endfunction

   function automatic int axis_width(input int ncomp, input int dw);
      return axis_bytes(ncomp, dw) * 8;
   endfunction

   // Counter width that stays legal for a range of a single value.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi4_stream_tpg_if.sv
// AXI4-Stream video bus carrying one pixel per beat.
interface axi4_stream_tpg_if #(
   parameter int M_AXIS_BYTES = 3
);
   localparam int M_AXIS_WIDTH = M_AXIS_BYTES * 8;

   logic [M_AXIS_WIDTH-1:0] TDATA;
   logic                    TVALID;
   logic                    TREADY;
   logic [M_AXIS_BYTES-1:0] TKEEP;
   logic [M_AXIS_BYTES-1:0] TSTRB;
   logic                    TUSER;
   logic                    TLAST;
   logic                    TID;
   logic                    TDEST;

   modport master (
      output TDATA, TVALID, TKEEP, TSTRB, TUSER, TLAST, TID, TDEST,
      input  TREADY
   );

   modport slave (
      input  TDATA, TVALID, TKEEP, TSTRB, TUSER, TLAST, TID, TDEST,
      output TREADY
   );
endinterface

// File: rtl/axi4_stream_tpg_pattern.sv
// Combinational pixel generator: maps (x, y, pattern) to a packed pixel word.
module axi4_stream_tpg_pattern
   import axi4_stream_tpg_pkg::*;
#(
   parameter int NUM_VIDEO_COMPONENTS = 3,
   parameter int MAXIMUM_DATA_WIDTH   = 8,
   parameter int ACTIVE_COLS          = 1920,
   parameter int XW                   = 11,
   parameter int YW                   = 11,
   parameter int PIX_W                = 24
)(
   input  logic [XW-1:0]    i_x,
   input  logic [YW-1:0]    i_y,
   input  pattern_t         i_pat,
   output logic [PIX_W-1:0] o_pixel
);
   localparam int DW = MAXIMUM_DATA_WIDTH;
   localparam int NC = NUM_VIDEO_COMPONENTS;
   localparam logic [XW-1:0] BAR_W   = XW'(ACTIVE_COLS / 8);
   localparam logic [XW-1:0] BAR_MAX = XW'(7);
   localparam logic [DW-1:0] HALF    = DW'(1) << (DW - 1);

   logic [XW-1:0]         w_bar_q;
   logic [2:0]            w_bar;
   logic [NC-1:0][DW-1:0] w_comp;

   // Columns past the eighth full bar (when ACTIVE_COLS is not a multiple of 8) stay on bar 7.
   assign w_bar_q = i_x / BAR_W;
   assign w_bar   = (w_bar_q > BAR_MAX) ? 3'd7 : w_bar_q[2:0];

   for (genvar c = 0; c < NC; c++) begin : g_comp
      logic w_bar_on;
      if (c < 3) begin : g_bar
         assign w_bar_on = w_bar[c];
      end else begin : g_nobar
         assign w_bar_on = 1'b0;
      end
      assign w_comp[c] = (i_pat == HRAMP) ? DW'(i_x) :
                         (i_pat == VRAMP) ? DW'(i_y) :
                         (i_pat == BARS)  ? {DW{w_bar_on}} : HALF;
   end

   assign o_pixel = PIX_W'(w_comp);

endmodule

// File: rtl/axi4_stream_tpg.sv
// AXI4-Stream video test pattern generator: frame FSM, raster counters, output register.
// Optional frame counter output enabled by defining AXI4_STREAM_TPG_FRAME_COUNT_EN.
module axi4_stream_tpg
   import axi4_stream_tpg_pkg::*;
#(
   parameter int NUM_VIDEO_COMPONENTS = 3,
   parameter int MAXIMUM_DATA_WIDTH   = 8,
   parameter int ACTIVE_COLS          = 1920,
   parameter int ACTIVE_ROWS          = 1080
)(
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                enable,
   input  logic [1:0]          pattern_sel,
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
   output logic [15:0]         frame_count,
`endif
   axi4_stream_tpg_if.master   m_axis_video
);
   localparam int M_AXIS_BYTES = axis_bytes(NUM_VIDEO_COMPONENTS, MAXIMUM_DATA_WIDTH);
   localparam int M_AXIS_WIDTH = axis_width(NUM_VIDEO_COMPONENTS, MAXIMUM_DATA_WIDTH);
   localparam int XW = cnt_width(ACTIVE_COLS);
   localparam int YW = cnt_width(ACTIVE_ROWS);
   localparam logic [XW-1:0] X_LAST = XW'(ACTIVE_COLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(ACTIVE_ROWS - 1);

   state_t                  r_state, w_state_nxt;
   logic [XW-1:0]           r_x, w_x_nxt;
   logic [YW-1:0]           r_y, w_y_nxt;
   pattern_t                r_pat, w_pat_nxt;
   logic                    r_tvalid, w_tvalid_nxt;
   logic                    r_tuser, r_tlast;
   logic [M_AXIS_WIDTH-1:0] r_tdata, w_pix;
   logic                    w_xfer, w_last_px, w_load;

   assign w_xfer    = r_tvalid & m_axis_video.TREADY;
   assign w_last_px = (r_x == X_LAST) && (r_y == Y_LAST);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   // w_load marks a cycle where the output register takes the next pixel.
   always_comb begin
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_pat_nxt    = r_pat;
      w_tvalid_nxt = r_tvalid;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nxt  = ACTIVE;
               w_x_nxt      = '0;
               w_y_nxt      = '0;
               w_pat_nxt    = pattern_t'(pattern_sel);
               w_tvalid_nxt = 1'b1;
               w_load       = 1'b1;
            end
         end
         ACTIVE: begin
            if (w_xfer) begin
               if (w_last_px) begin
                  w_x_nxt = '0;
                  w_y_nxt = '0;
                  if (enable) begin
                     w_pat_nxt = pattern_t'(pattern_sel);
                     w_load    = 1'b1;
                  end else begin
                     w_state_nxt  = IDLE;
                     w_tvalid_nxt = 1'b0;
                  end
               end else begin
                  w_load = 1'b1;
                  if (r_x == X_LAST) begin
                     w_x_nxt = '0;
                     w_y_nxt = r_y + 1'b1;
                  end else begin
                     w_x_nxt = r_x + 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   axi4_stream_tpg_pattern #(
      .NUM_VIDEO_COMPONENTS (NUM_VIDEO_COMPONENTS),
      .MAXIMUM_DATA_WIDTH   (MAXIMUM_DATA_WIDTH),
      .ACTIVE_COLS          (ACTIVE_COLS),
      .XW                   (XW),
      .YW                   (YW),
      .PIX_W                (M_AXIS_WIDTH)
   ) u_pattern (
      .i_x     (w_x_nxt),
      .i_y     (w_y_nxt),
      .i_pat   (w_pat_nxt),
      .o_pixel (w_pix)
   );

   // Output beat is computed from the next coordinates so TDATA stays registered.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_pat    <= HRAMP;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tuser  <= 1'b0;
         r_tlast  <= 1'b0;
      end else begin
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_pat    <= w_pat_nxt;
         r_tvalid <= w_tvalid_nxt;
         if (w_load) begin
            r_tdata <= w_pix;
            r_tuser <= (w_x_nxt == '0) && (w_y_nxt == '0);
            r_tlast <= (w_x_nxt == X_LAST);
         end else if (!w_tvalid_nxt) begin
            r_tdata <= '0;
            r_tuser <= 1'b0;
            r_tlast <= 1'b0;
         end
      end
   end

`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
   logic [15:0] r_frame_count;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)                r_frame_count <= '0;
      else if (w_xfer && w_last_px) r_frame_count <= r_frame_count + 16'd1;
   end

   assign frame_count = r_frame_count;
`endif

   assign m_axis_video.TDATA  = r_tdata;
   assign m_axis_video.TVALID = r_tvalid;
   assign m_axis_video.TUSER  = r_tuser;
   assign m_axis_video.TLAST  = r_tlast;
   assign m_axis_video.TKEEP  = {M_AXIS_BYTES{1'b1}};
   assign m_axis_video.TSTRB  = {M_AXIS_BYTES{1'b1}};
   assign m_axis_video.TID    = 1'b0;
   assign m_axis_video.TDEST  = 1'b0;

endmodule

// File: tb/tb_axi4_stream_tpg.sv
// Directed bench for axi4_stream_tpg at 16x4, 3x8-bit components.
module tb_axi4_stream_tpg;

   logic       ap_clk;
   logic       ap_rst_n;
   logic       enable;
   logic [1:0] pattern_sel;
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   axi4_stream_tpg_if #(.M_AXIS_BYTES(3)) axis ();

   axi4_stream_tpg #(
      .NUM_VIDEO_COMPONENTS (3),
      .MAXIMUM_DATA_WIDTH   (8),
      .ACTIVE_COLS          (16),
      .ACTIVE_ROWS          (4)
   ) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .enable       (enable),
      .pattern_sel  (pattern_sel),
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
      .frame_count  (frame_count),
`endif
      .m_axis_video (axis)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc;

   logic [23:0] q_data[$];
   bit          q_user[$];
   bit          q_last[$];
   logic [23:0] bars_tbl [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Collects n accepted beats starting at the current negedge; checks hold-stable on stalls.
   task automatic collect(input int n, input bit rnd, input int drop_at, output int cycles);
      logic [23:0] pd;
      logic        pu, pl;
      bit          pstall;
      int          limit;
      q_data.delete();
      q_user.delete();
      q_last.delete();
      cycles = 0;
      pstall = 1'b0;
      pd = '0; pu = 1'b0; pl = 1'b0;
      limit  = n * 8 + 50;
      while (q_data.size() < n && cycles < limit) begin
         if (pstall) begin
            chk("stall_valid", 32'(axis.TVALID), 32'd1);
            chk("stall_data",  32'(axis.TDATA), 32'(pd));
            chk("stall_user",  32'(axis.TUSER), 32'(pu));
            chk("stall_last",  32'(axis.TLAST), 32'(pl));
         end
         axis.TREADY = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (axis.TVALID && axis.TREADY) begin
            q_data.push_back(axis.TDATA);
            q_user.push_back(axis.TUSER);
            q_last.push_back(axis.TLAST);
            if (q_data.size() - 1 == drop_at) enable = 1'b0;
         end
         pstall = axis.TVALID && !axis.TREADY;
         pd = axis.TDATA; pu = axis.TUSER; pl = axis.TLAST;
         cycles++;
         @(negedge ap_clk);
      end
      chk("beats_collected", 32'(q_data.size()), 32'(n));
   endtask

   // kind: 0 h-ramp, 1 v-ramp, 2 bars, 3 flat
   task automatic check_seq(input string tag, input int kind);
      for (int i = 0; i < q_data.size(); i++) begin
         int x, y;
         logic [23:0] e;
         x = i % 16;
         y = i / 16;
         case (kind)
            0:       e = {3{8'(x)}};
            1:       e = {3{8'(y)}};
            2:       e = bars_tbl[x / 2];
            default: e = 24'h808080;
         endcase
         chk($sformatf("%s_data[%0d]", tag, i), 32'(q_data[i]), 32'(e));
         chk($sformatf("%s_user[%0d]", tag, i), 32'(q_user[i]), 32'(i == 0));
         chk($sformatf("%s_last[%0d]", tag, i), 32'(q_last[i]), 32'(x == 15));
      end
   endtask

   initial begin
      ap_rst_n    = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      axis.TREADY = 1'b0;
      repeat (2) @(negedge ap_clk);
      chk("rst_tvalid", 32'(axis.TVALID), 32'd0);
      chk("rst_tdata",  32'(axis.TDATA),  32'd0);
      chk("rst_tuser",  32'(axis.TUSER),  32'd0);
      chk("rst_tlast",  32'(axis.TLAST),  32'd0);
      chk("rst_tkeep",  32'(axis.TKEEP),  32'h7);
      chk("rst_tstrb",  32'(axis.TSTRB),  32'h7);
      chk("rst_tid",    32'(axis.TID),    32'd0);
      chk("rst_tdest",  32'(axis.TDEST),  32'd0);
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
      chk("rst_frame_count", 32'(frame_count), 32'd0);
`endif
      ap_rst_n = 1'b1;
      repeat (3) @(negedge ap_clk);
      chk("idle_tvalid", 32'(axis.TVALID), 32'd0);

      // Frame A: h-ramp; the mid-frame select change must not take effect until frame B.
      enable = 1'b1;
      pattern_sel = 2'd0;
      @(negedge ap_clk);
      chk("lat_tvalid", 32'(axis.TVALID), 32'd1);
      chk("lat_tuser",  32'(axis.TUSER),  32'd1);
      chk("lat_tdata",  32'(axis.TDATA),  32'd0);
      pattern_sel = 2'd2;
      collect(64, 1'b0, -1, cyc);
      chk("A_cycles", 32'(cyc), 32'd64);
      check_seq("A", 0);

      // Frame B: bars, back-to-back with A; enable dropped after beat 20.
      collect(64, 1'b0, 20, cyc);
      chk("B_cycles_no_gap", 32'(cyc), 32'd64);
      check_seq("B", 2);
      chk("B_end_tvalid", 32'(axis.TVALID), 32'd0);
      repeat (2) @(negedge ap_clk);
      chk("B_idle_tvalid", 32'(axis.TVALID), 32'd0);

      // Frame C: h-ramp with random backpressure.
      pattern_sel = 2'd0;
      enable = 1'b1;
      @(negedge ap_clk);
      collect(64, 1'b1, 0, cyc);
      check_seq("C", 0);
      chk("C_end_tvalid", 32'(axis.TVALID), 32'd0);
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
      chk("frame_count_3", 32'(frame_count), 32'd3);
`endif

      // Frame D: v-ramp aborted by reset at beat 30.
      pattern_sel = 2'd1;
      enable = 1'b1;
      @(negedge ap_clk);
      collect(30, 1'b0, -1, cyc);
      check_seq("D", 1);
      ap_rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 32'(axis.TVALID), 32'd0);
      chk("arst_tdata",  32'(axis.TDATA),  32'd0);
      chk("arst_tuser",  32'(axis.TUSER),  32'd0);
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
      chk("arst_frame_count", 32'(frame_count), 32'd0);
`endif
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      chk("post_rst_tvalid", 32'(axis.TVALID), 32'd1);
      chk("post_rst_tuser",  32'(axis.TUSER),  32'd1);
      chk("post_rst_tdata",  32'(axis.TDATA),  32'd0);

      // Frame E: full v-ramp; frame F: flat, selected mid-frame E.
      pattern_sel = 2'd3;
      collect(64, 1'b0, -1, cyc);
      check_seq("E", 1);
`ifdef AXI4_STREAM_TPG_FRAME_COUNT_EN
      chk("frame_count_after_rst", 32'(frame_count), 32'd1);
`endif
      collect(8, 1'b0, -1, cyc);
      check_seq("F", 3);
      enable = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_stream_tpg.md
AXI4_STREAM_TPG -- requirements
Module: axi4_stream_tpg

Interface
REQ-001 SHALL have parameter NUM_VIDEO_COMPONENTS, default 3: components per pixel.
REQ-002 SHALL have parameter MAXIMUM_DATA_WIDTH, default 8: bits per component.
REQ-003 SHALL have parameter ACTIVE_COLS, default 1920: pixels per line (>=8).
REQ-004 SHALL have parameter ACTIVE_ROWS, default 1080: lines per frame (>=1).
REQ-005 SHALL have derived widths M_AXIS_BYTES = (NUM_VIDEO_COMPONENTS*MAXIMUM_DATA_WIDTH+7)/8 and M_AXIS_WIDTH = M_AXIS_BYTES*8; one sample per clock.
REQ-006 SHALL have ap_clk  input  1  sole clock, all logic rising-edge.
REQ-007 SHALL have ap_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have enable  input  1  run request, sampled at frame boundaries.
REQ-009 SHALL have pattern_sel  input  2  pattern select, latched at frame start.
REQ-010 SHALL have m_axis_video_TDATA  output  M_AXIS_WIDTH  pixel; component c in bits [c*MAXIMUM_DATA_WIDTH +: MAXIMUM_DATA_WIDTH], pad bits 0.
REQ-011 SHALL have m_axis_video_TVALID output 1, m_axis_video_TREADY input 1, TKEEP/TSTRB outputs M_AXIS_BYTES, TUSER/TLAST/TID/TDEST outputs 1.

Function
REQ-012 SHALL implement states IDLE and ACTIVE; x counter [0,ACTIVE_COLS-1], y counter [0,ACTIVE_ROWS-1].
REQ-013 IDLE: TVALID=0; enable=1 at an edge -> ACTIVE, x=y=0, pattern_sel latched, TVALID=1 from that edge (1-cycle latency).
REQ-014 Transfer occurs only on TVALID&&TREADY; while TVALID=1 and TREADY=0, TDATA/TUSER/TLAST SHALL hold stable.
REQ-015 On transfer x increments; at x=ACTIVE_COLS-1 x wraps to 0 and y increments; at last pixel (x=ACTIVE_COLS-1, y=ACTIVE_ROWS-1) frame ends.
REQ-016 At frame end: enable=1 -> stay ACTIVE, x=y=0, re-latch pattern_sel, TVALID stays 1 (no bubble); enable=0 -> IDLE, TVALID=0 next cycle.
REQ-017 enable deassertion mid-frame SHALL NOT truncate the frame; pattern_sel changes mid-frame SHALL be ignored.
REQ-018 TUSER=1 only for pixel (0,0); TLAST=1 only when x=ACTIVE_COLS-1.
REQ-019 TKEEP, TSTRB all ones; TID=0; TDEST=0.
REQ-020 Pattern 0 (h-ramp): every component = x mod 2^MAXIMUM_DATA_WIDTH.
REQ-021 Pattern 1 (v-ramp): every component = y mod 2^MAXIMUM_DATA_WIDTH.
REQ-022 Pattern 2 (bars): b = min(x/(ACTIVE_COLS/8),7); component c<3 = all ones if bit c of b set else 0; components c>=3 = 0.
REQ-023 Pattern 3 (flat): every component = 2^(MAXIMUM_DATA_WIDTH-1).
REQ-024 TDATA SHALL be registered; no combinational path from TREADY to any output except none (TVALID registered too).

Reset
REQ-025 ap_rst_n=0 SHALL asynchronously force IDLE, x=y=0, TVALID=0, TDATA=0, TUSER=0, TLAST=0, latched pattern=0, frame counter=0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release the next frame starts at (0,0) with TUSER=1.

Configuration
REQ-027 Macro AXI4_STREAM_TPG_FRAME_COUNT_EN defined: SHALL add output frame_count [15:0], incremented on each completed frame transfer, wrapping 65535->0.
REQ-028 Macro undefined: frame_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package axi4_stream_tpg_pkg SHALL hold the state enum (IDLE, ACTIVE), pattern enum (HRAMP=0, VRAMP=1, BARS=2, FLAT=3) and width-derivation functions.
REQ-030 Sub-module axi4_stream_tpg_pattern SHALL compute the pixel combinationally from (x, y, latched pattern); top holds FSM, counters, output register.

Verification (ACTIVE_COLS=16, ACTIVE_ROWS=4, 3x8)
REQ-031 enable=1, TREADY=1, sel=0 -> 64 beats, TUSER at beat 0 only, TLAST at beats 15/31/47/63, component = x (0..15).
REQ-032 sel=2, TREADY=1 -> x=0..1 data 0x000000, x=2..3 0x0000FF, x=14..15 0xFFFFFF.
REQ-033 TREADY random 50% -> identical beat sequence to REQ-031; outputs stable across every stall cycle.
REQ-034 enable dropped at beat 20 -> frame completes at beat 63, TVALID=0 from next cycle; held 1 -> beat 64 is (0,0) with TUSER=1, no gap.
REQ-035 ap_rst_n pulsed at beat 30 -> TVALID=0 immediately; after release and enable=1 first beat has TUSER=1, x=0.
REQ-036 With AXI4_STREAM_TPG_FRAME_COUNT_EN, 3 frames -> frame_count=3; without, frame_count port absent and stream identical.
